mrd_stage_seq: RTL and testbench
================================

Name: mrd_stage_seq

Overview:
Stage/group sequencer for the mixed radix DFT engine. It takes the factorisation computed by the control block (number of factors, per-stage radix, N/Nf, twiddle denominator) and issues one butterfly command per group, stage by stage, to the radix-2/3/4/5 datapath under a valid/ready handshake. Between stages it inserts a fixed flush gap so the memory/datapath pipeline drains. It then reports completion to the top-level FSM.

Parameters:
MAX_STAGES, 6, maximum number of radix stages.
PTS_W, 12, width of group counters, N/Nf and twiddle fields.
GAP_CYC, 8, idle cycles inserted after the last accepted command of every stage (>=1).

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
start  in  1  one-cycle request to run a DFT; ignored while busy
num_factors  in  3  number of stages, 1..6
nf  in  6x3  radix per stage, stage 0 in the MS slice; legal values 2,3,4,5
dftpts_div_nf  in  6x12  groups per stage (N/Nf[s])
twdl_demontr  in  6x12  Nf[s]*...*Nf[last] per stage
bfly_valid  out  1  command valid
bfly_ready  in  1  datapath accepts command
stage_idx  out  3  current stage
factor  out  3  radix of current stage
grp_idx  out  12  group index within stage
twdl_numrtr_1  out  12  grp_idx mod twdl_demontr[stage]
twdl_demontr_o  out  12  twdl_demontr of current stage
first_grp  out  1  grp_idx==0 on this command
last_grp  out  1  grp_idx==dftpts_div_nf[stage]-1 on this command
busy  out  1  sequence in progress
done  out  1  one-cycle completion pulse
cfg_err  out  1  one-cycle pulse: configuration rejected

Behaviour:
- Reset: state IDLE; every output 0; config registers 0. Reset mid-run aborts immediately; no done, no cfg_err.
- States: IDLE, LOAD, RUN, GAP, DONE.
- IDLE: start=1 -> latch all config inputs; go to LOAD. busy=0.
- LOAD (1 cycle, busy=1): check config. Error if num_factors==0 or >MAX_STAGES, any active stage nf not in {2,3,4,5}, or dftpts_div_nf==0 or twdl_demontr==0 for any active stage. Stages >= num_factors are not checked. On error: cfg_err=1 for this cycle, busy drops next cycle -> IDLE. Otherwise -> RUN with stage=0, grp=0, numerator=0.
- RUN: bfly_valid=1. All command fields are registered and held stable until a transfer (bfly_valid & bfly_ready). On transfer:
  - if not last group: grp+1; numerator+1, wrapping to 0 when it equals twdl_demontr-1 (no divider).
  - if last group: bfly_valid drops next cycle -> GAP.
- GAP: bfly_valid=0 for exactly GAP_CYC cycles. Then, if stage<num_factors-1: stage+1, grp=0, numerator=0 -> RUN. Else -> DONE.
- DONE (1 cycle): done=1, busy=1 -> IDLE.
- busy is high in LOAD, RUN, GAP and DONE.
- Latency: start sampled at cycle 0 -> LOAD at cycle 1 -> first bfly_valid at cycle 2.
- start during busy is ignored. start in the DONE cycle is ignored; a new start is accepted from IDLE only.
- bfly_ready stuck low holds RUN indefinitely with stable fields. Ready while valid=0 has no effect.
- Input config changes after LOAD have no effect on a run in progress.
- Widths: grp and numerator are PTS_W bits; internal counters never exceed their limits, so there is no overflow.

Test Plan:
- 12-pt run (num_factors=2, nf={4,3}, div={3,4}, demontr={12,3}), ready=1, start at cycle 0. Transfers at cycles 2,3,4 (stage0, grp 0..2, numerator 0,1,2, factor 4). Transfers at cycles 13..16 (stage1, grp 0..3, numerator 0,1,2,0, factor 3). done at cycle 25; busy high on cycles 1..25.
- Same config, ready toggling 1,0,1,0,…. Every command is held while ready=0. Exactly 7 transfers in the order above, with no duplicates or skips. GAP still lasts 8 cycles after each last_grp transfer.
- num_factors=0, then a separate run with nf[1]=6 (num_factors=2). Each gives cfg_err high at cycle 1 only, no bfly_valid, busy low from cycle 2. Stage-2 garbage with num_factors=2 produces no error.
- Single stage N=5 (num_factors=1, nf={5}, div={1}, demontr={5}). One transfer at cycle 2 with first_grp=last_grp=1. done at cycle 11.
- start pulsed during RUN and in the DONE cycle: ignored, with no restart and no second done. Next start from IDLE runs normally.
- rst asserted in GAP of stage0 of the 12-pt run. All outputs are 0 the next cycle and no done is issued. A subsequent start reproduces the first scenario exactly.

Source files
------------

// File: rtl/mrd_stage_seq.sv
// Stage/group sequencer for the mixed radix DFT engine: walks every group of
// every radix stage, issuing one butterfly command per group with a flush gap between stages.
module mrd_stage_seq #(
  parameter int MAX_STAGES = 6,
  parameter int PTS_W      = 12,
  parameter int GAP_CYC    = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [2:0]                  num_factors,
  input  logic [MAX_STAGES*3-1:0]     nf,
  input  logic [MAX_STAGES*PTS_W-1:0] dftpts_div_nf,
  input  logic [MAX_STAGES*PTS_W-1:0] twdl_demontr,
  output logic                        bfly_valid,
  input  logic                        bfly_ready,
  output logic [2:0]                  stage_idx,
  output logic [2:0]                  factor,
  output logic [PTS_W-1:0]            grp_idx,
  output logic [PTS_W-1:0]            twdl_numrtr_1,
  output logic [PTS_W-1:0]            twdl_demontr_o,
  output logic                        first_grp,
  output logic                        last_grp,
  output logic                        busy,
  output logic                        done,
  output logic                        cfg_err
);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_LOAD = 3'd1;
  localparam logic [2:0] ST_RUN  = 3'd2;
  localparam logic [2:0] ST_GAP  = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;
  localparam int GAP_W = $clog2(GAP_CYC + 1);

  logic [2:0]       state_r, nxt_state_s;
  logic [GAP_W-1:0] gap_cnt_r;
  logic [2:0]       nfac_r;
  logic [2:0]       nf_a_r  [MAX_STAGES];
  logic [PTS_W-1:0] div_a_r [MAX_STAGES];
  logic [PTS_W-1:0] dm_a_r  [MAX_STAGES];
  logic [2:0]       nf_in_s  [MAX_STAGES];
  logic [PTS_W-1:0] div_in_s [MAX_STAGES];
  logic [PTS_W-1:0] dm_in_s  [MAX_STAGES];
  logic             cfg_bad_s;

  logic             bfly_valid_r, busy_r, done_r, cfg_err_r;
  logic [2:0]       stage_r, factor_r;
  logic [PTS_W-1:0] grp_r, num_r, dm_o_r;
  logic             first_r, last_r;

  logic             load_fields_s;
  logic [2:0]       nxt_stage_s;
  logic [PTS_W-1:0] nxt_grp_s, nxt_num_s;

  // Unpack the raw configuration buses (stage 0 in the MS slice) and validate them.
  always_comb begin
    cfg_bad_s = (num_factors == 3'd0) || (int'(num_factors) > MAX_STAGES);
    for (int s = 0; s < MAX_STAGES; s++) begin
      nf_in_s[s]  = nf[(MAX_STAGES-1-s)*3 +: 3];
      div_in_s[s] = dftpts_div_nf[(MAX_STAGES-1-s)*PTS_W +: PTS_W];
      dm_in_s[s]  = twdl_demontr[(MAX_STAGES-1-s)*PTS_W +: PTS_W];
      if (s < int'(num_factors)) begin
        if ((nf_in_s[s] < 3'd2) || (nf_in_s[s] > 3'd5) ||
            (div_in_s[s] == '0) || (dm_in_s[s] == '0)) begin
          cfg_bad_s = 1'b1;
        end else begin
          cfg_bad_s = cfg_bad_s;
        end
      end else begin
        cfg_bad_s = cfg_bad_s;
      end
    end
  end

  // Next-state and next-command computation.
  always_comb begin
    nxt_state_s   = state_r;
    load_fields_s = 1'b0;
    nxt_stage_s   = stage_r;
    nxt_grp_s     = grp_r;
    nxt_num_s     = num_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          nxt_state_s = ST_LOAD;
        end else begin
          nxt_state_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (cfg_err_r) begin
          nxt_state_s = ST_IDLE;
        end else begin
          nxt_state_s   = ST_RUN;
          load_fields_s = 1'b1;
          nxt_stage_s   = 3'd0;
          nxt_grp_s     = '0;
          nxt_num_s     = '0;
        end
      end
      ST_RUN: begin
        if (bfly_valid_r && bfly_ready) begin
          if (last_r) begin
            nxt_state_s = ST_GAP;
          end else begin
            load_fields_s = 1'b1;
            nxt_grp_s     = grp_r + PTS_W'(1);
            // Numerator tracks grp mod denominator by wrapping, avoiding a divider.
            nxt_num_s     = (num_r == dm_o_r - PTS_W'(1)) ? '0 : num_r + PTS_W'(1);
          end
        end else begin
          nxt_state_s = ST_RUN;
        end
      end
      ST_GAP: begin
        if (gap_cnt_r == GAP_W'(GAP_CYC - 1)) begin
          if (stage_r < nfac_r - 3'd1) begin
            nxt_state_s   = ST_RUN;
            load_fields_s = 1'b1;
            nxt_stage_s   = stage_r + 3'd1;
            nxt_grp_s     = '0;
            nxt_num_s     = '0;
          end else begin
            nxt_state_s = ST_DONE;
          end
        end else begin
          nxt_state_s = ST_GAP;
        end
      end
      ST_DONE: nxt_state_s = ST_IDLE;
      default: nxt_state_s = ST_IDLE;
    endcase
  end

  // State, configuration latch and registered command/status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      gap_cnt_r    <= '0;
      nfac_r       <= 3'd0;
      bfly_valid_r <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      cfg_err_r    <= 1'b0;
      stage_r      <= 3'd0;
      factor_r     <= 3'd0;
      grp_r        <= '0;
      num_r        <= '0;
      dm_o_r       <= '0;
      first_r      <= 1'b0;
      last_r       <= 1'b0;
      for (int s = 0; s < MAX_STAGES; s++) begin
        nf_a_r[s]  <= 3'd0;
        div_a_r[s] <= '0;
        dm_a_r[s]  <= '0;
      end
    end else begin
      state_r      <= nxt_state_s;
      busy_r       <= (nxt_state_s != ST_IDLE);
      bfly_valid_r <= (nxt_state_s == ST_RUN);
      done_r       <= (nxt_state_s == ST_DONE);
      // Error is flagged while the config is latched so the pulse lands in the LOAD cycle.
      cfg_err_r    <= (state_r == ST_IDLE) && start && cfg_bad_s;
      gap_cnt_r    <= (state_r == ST_GAP) ? gap_cnt_r + GAP_W'(1) : '0;
      if ((state_r == ST_IDLE) && start) begin
        nfac_r <= num_factors;
        for (int s = 0; s < MAX_STAGES; s++) begin
          nf_a_r[s]  <= nf_in_s[s];
          div_a_r[s] <= div_in_s[s];
          dm_a_r[s]  <= dm_in_s[s];
        end
      end
      if (load_fields_s) begin
        stage_r  <= nxt_stage_s;
        grp_r    <= nxt_grp_s;
        num_r    <= nxt_num_s;
        factor_r <= nf_a_r[nxt_stage_s];
        dm_o_r   <= dm_a_r[nxt_stage_s];
        first_r  <= (nxt_grp_s == '0);
        last_r   <= (nxt_grp_s == div_a_r[nxt_stage_s] - PTS_W'(1));
      end
    end
  end

  assign bfly_valid     = bfly_valid_r;
  assign busy           = busy_r;
  assign done           = done_r;
  assign cfg_err        = cfg_err_r;
  assign stage_idx      = stage_r;
  assign factor         = factor_r;
  assign grp_idx        = grp_r;
  assign twdl_numrtr_1  = num_r;
  assign twdl_demontr_o = dm_o_r;
  assign first_grp      = first_r;
  assign last_grp       = last_r;

endmodule

// File: tb/tb_mrd_stage_seq.sv
// Directed self-checking bench for mrd_stage_seq: cycle-accurate command,
// gap, completion and error timing against hand-computed tables.
module tb_mrd_stage_seq;

  logic        clk = 1'b0;
  logic        rst, start, bfly_ready;
  logic [2:0]  num_factors;
  logic [17:0] nf;
  logic [71:0] div_nf, demontr;
  logic        bfly_valid, first_grp, last_grp, busy, done, cfg_err;
  logic [2:0]  stage_idx, factor;
  logic [11:0] grp_idx, twdl_numrtr_1, twdl_demontr_o;

  mrd_stage_seq dut (
    .clk(clk), .rst(rst), .start(start), .num_factors(num_factors), .nf(nf),
    .dftpts_div_nf(div_nf), .twdl_demontr(demontr), .bfly_valid(bfly_valid),
    .bfly_ready(bfly_ready), .stage_idx(stage_idx), .factor(factor), .grp_idx(grp_idx),
    .twdl_numrtr_1(twdl_numrtr_1), .twdl_demontr_o(twdl_demontr_o), .first_grp(first_grp),
    .last_grp(last_grp), .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  // Expected 12-point command sequence
  int e_cyc[7]   = '{2, 3, 4, 13, 14, 15, 16};
  int e_tcyc[7]  = '{2, 4, 6, 16, 18, 20, 22};
  int e_stage[7] = '{0, 0, 0, 1, 1, 1, 1};
  int e_grp[7]   = '{0, 1, 2, 0, 1, 2, 3};
  int e_num[7]   = '{0, 1, 2, 0, 1, 2, 0};
  int e_fac[7]   = '{4, 4, 4, 3, 3, 3, 3};
  int e_dm[7]    = '{12, 12, 12, 3, 3, 3, 3};
  int e_first[7] = '{1, 0, 0, 1, 0, 0, 0};
  int e_last[7]  = '{0, 0, 1, 0, 0, 0, 1};

  int          n_x, n_done, done_cyc, hold_err;
  int          x_cyc[16];
  logic [43:0] x_tup[16];
  logic [63:0] busy_m, valid_m, err_m;
  logic        zero_after_rst;

  function automatic logic [43:0] exp_tup(input int i);
    return {3'(e_stage[i]), 12'(e_grp[i]), 12'(e_num[i]), 3'(e_fac[i]),
            12'(e_dm[i]), 1'(e_first[i]), 1'(e_last[i])};
  endfunction

  task automatic cfg_12pt();
    num_factors = 3'd2;
    nf      = {3'd4, 3'd3, 12'd0};
    div_nf  = {12'd3, 12'd4, 48'd0};
    demontr = {12'd12, 12'd3, 48'd0};
  endtask

  // Pulse start at cycle 0 and record everything the DUT does for max_cyc cycles.
  task automatic collect(input int max_cyc, input bit tog, input int s1, input int s2, input int rc);
    logic [43:0] held_tup;
    logic        held;
    n_x = 0; n_done = 0; done_cyc = -1; hold_err = 0;
    busy_m = '0; valid_m = '0; err_m = '0; zero_after_rst = 1'b0;
    held = 1'b0; held_tup = '0;
    start = 1'b1; rst = 1'b0; bfly_ready = 1'b1;
    for (int c = 1; c <= max_cyc; c++) begin
      @(posedge clk); #1;
      if (c == rc + 1)
        zero_after_rst = ({bfly_valid, stage_idx, factor, grp_idx, twdl_numrtr_1, twdl_demontr_o,
                           first_grp, last_grp, busy, done, cfg_err} == '0);
      start = (c == s1) || (c == s2);
      rst = (c == rc);
      bfly_ready = tog ? (c % 2 == 0) : 1'b1;
      if (c < 64) begin
        busy_m[c] = busy; valid_m[c] = bfly_valid; err_m[c] = cfg_err;
      end
      if (done) begin
        n_done++; done_cyc = c;
      end
      if (held && bfly_valid &&
          {stage_idx, grp_idx, twdl_numrtr_1, factor, twdl_demontr_o, first_grp, last_grp} != held_tup)
        hold_err++;
      held = 1'b0;
      if (bfly_valid && bfly_ready) begin
        if (n_x < 16) begin
          x_cyc[n_x] = c;
          x_tup[n_x] = {stage_idx, grp_idx, twdl_numrtr_1, factor, twdl_demontr_o, first_grp, last_grp};
        end
        n_x++;
      end else if (bfly_valid) begin
        held = 1'b1;
        held_tup = {stage_idx, grp_idx, twdl_numrtr_1, factor, twdl_demontr_o, first_grp, last_grp};
      end
    end
    start = 1'b0; rst = 1'b0; bfly_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; bfly_ready = 1'b0;
    cfg_12pt();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bfly_valid, busy, done, cfg_err, first_grp, last_grp} !== 6'b0)
      $display("FAIL reset_flags got=%b want=000000", {bfly_valid, busy, done, cfg_err, first_grp, last_grp});
    else passed++;
    checks++;
    if ({stage_idx, factor, grp_idx, twdl_numrtr_1, twdl_demontr_o} !== 42'd0)
      $display("FAIL reset_fields got=%h want=0", {stage_idx, factor, grp_idx, twdl_numrtr_1, twdl_demontr_o});
    else passed++;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_12pt();
    cfg_12pt();
    collect(30, 1'b0, -1, -1, -1);
    checks++;
    if (n_x !== 7) $display("FAIL 12pt_count got=%0d want=7", n_x); else passed++;
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (x_cyc[i] !== e_cyc[i] || x_tup[i] !== exp_tup(i))
        $display("FAIL 12pt_xfer%0d got cyc=%0d tup=%h want cyc=%0d tup=%h", i, x_cyc[i], x_tup[i], e_cyc[i], exp_tup(i));
      else passed++;
    end
    checks++;
    if (done_cyc !== 25 || n_done !== 1)
      $display("FAIL 12pt_done got cyc=%0d n=%0d want cyc=25 n=1", done_cyc, n_done);
    else passed++;
    checks++;
    if (busy_m !== 64'h0000_0000_03FF_FFFE)
      $display("FAIL 12pt_busy got=%h want=%h", busy_m, 64'h0000_0000_03FF_FFFE);
    else passed++;
    checks++;
    if (valid_m !== 64'h0000_0000_0001_E01C)
      $display("FAIL 12pt_valid got=%h want=%h", valid_m, 64'h0000_0000_0001_E01C);
    else passed++;
  endtask

  task automatic test_ready_toggle();
    cfg_12pt();
    collect(36, 1'b1, -1, -1, -1);
    checks++;
    if (n_x !== 7) $display("FAIL tog_count got=%0d want=7", n_x); else passed++;
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (x_cyc[i] !== e_tcyc[i] || x_tup[i] !== exp_tup(i))
        $display("FAIL tog_xfer%0d got cyc=%0d tup=%h want cyc=%0d tup=%h", i, x_cyc[i], x_tup[i], e_tcyc[i], exp_tup(i));
      else passed++;
    end
    checks++;
    if (hold_err !== 0) $display("FAIL tog_hold got=%0d want=0", hold_err); else passed++;
    checks++;
    if (valid_m[15:7] !== 9'b1_0000_0000 || valid_m[31:23] !== 9'b0)
      $display("FAIL tog_gap got=%b/%b want=100000000/000000000", valid_m[15:7], valid_m[31:23]);
    else passed++;
    checks++;
    if (done_cyc !== 31 || n_done !== 1)
      $display("FAIL tog_done got cyc=%0d n=%0d want cyc=31 n=1", done_cyc, n_done);
    else passed++;
  endtask

  task automatic test_cfg_err();
    cfg_12pt();
    num_factors = 3'd0;
    collect(8, 1'b0, -1, -1, -1);
    checks++;
    if (err_m !== 64'h2 || busy_m !== 64'h2 || valid_m !== 64'h0 || n_done !== 0)
      $display("FAIL err_nf0 got err=%h busy=%h valid=%h done=%0d want 2/2/0/0", err_m, busy_m, valid_m, n_done);
    else passed++;
    cfg_12pt();
    nf = {3'd4, 3'd6, 12'd0};
    collect(8, 1'b0, -1, -1, -1);
    checks++;
    if (err_m !== 64'h2 || busy_m !== 64'h2 || valid_m !== 64'h0 || n_done !== 0)
      $display("FAIL err_radix6 got err=%h busy=%h valid=%h done=%0d want 2/2/0/0", err_m, busy_m, valid_m, n_done);
    else passed++;
    cfg_12pt();
    nf = {3'd4, 3'd3, 3'd7, 9'd0};
    collect(28, 1'b0, -1, -1, -1);
    checks++;
    if (err_m !== 64'h0 || n_x !== 7 || done_cyc !== 25)
      $display("FAIL err_garbage got err=%h xfers=%0d done=%0d want 0/7/25", err_m, n_x, done_cyc);
    else passed++;
  endtask

  task automatic test_single();
    num_factors = 3'd1;
    nf      = {3'd5, 15'd0};
    div_nf  = {12'd1, 60'd0};
    demontr = {12'd5, 60'd0};
    collect(14, 1'b0, -1, -1, -1);
    checks++;
    if (n_x !== 1 || x_cyc[0] !== 2 || x_tup[0] !== {3'd0, 12'd0, 12'd0, 3'd5, 12'd5, 1'b1, 1'b1})
      $display("FAIL single_xfer got n=%0d cyc=%0d tup=%h want n=1 cyc=2 tup=%h", n_x, x_cyc[0], x_tup[0],
               {3'd0, 12'd0, 12'd0, 3'd5, 12'd5, 1'b1, 1'b1});
    else passed++;
    checks++;
    if (done_cyc !== 11 || n_done !== 1)
      $display("FAIL single_done got cyc=%0d n=%0d want cyc=11 n=1", done_cyc, n_done);
    else passed++;
  endtask

  task automatic test_start_ignored();
    cfg_12pt();
    collect(40, 1'b0, 3, 25, -1);
    checks++;
    if (n_done !== 1 || done_cyc !== 25 || n_x !== 7)
      $display("FAIL ign_done got n=%0d cyc=%0d xfers=%0d want 1/25/7", n_done, done_cyc, n_x);
    else passed++;
    checks++;
    if (busy_m !== 64'h0000_0000_03FF_FFFE)
      $display("FAIL ign_busy got=%h want=%h", busy_m, 64'h0000_0000_03FF_FFFE);
    else passed++;
    collect(28, 1'b0, -1, -1, -1);
    checks++;
    if (n_done !== 1 || done_cyc !== 25 || n_x !== 7)
      $display("FAIL ign_rerun got n=%0d cyc=%0d xfers=%0d want 1/25/7", n_done, done_cyc, n_x);
    else passed++;
  endtask

  task automatic test_reset_midrun();
    cfg_12pt();
    collect(30, 1'b0, -1, -1, 7);
    checks++;
    if (zero_after_rst !== 1'b1) $display("FAIL rst_zero got=%b want=1", zero_after_rst); else passed++;
    checks++;
    if (n_done !== 0 || n_x !== 3 || busy_m[29:8] !== 22'd0)
      $display("FAIL rst_abort got done=%0d xfers=%0d busy=%h want 0/3/0", n_done, n_x, busy_m[29:8]);
    else passed++;
    collect(28, 1'b0, -1, -1, -1);
    checks++;
    if (n_x !== 7 || done_cyc !== 25 || n_done !== 1 || busy_m !== 64'h0000_0000_03FF_FFFE)
      $display("FAIL rst_rerun got xfers=%0d done=%0d/%0d busy=%h want 7/25/1/3fffffe", n_x, done_cyc, n_done, busy_m);
    else passed++;
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (x_cyc[i] !== e_cyc[i] || x_tup[i] !== exp_tup(i))
        $display("FAIL rst_xfer%0d got cyc=%0d tup=%h want cyc=%0d tup=%h", i, x_cyc[i], x_tup[i], e_cyc[i], exp_tup(i));
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_12pt();
    test_ready_toggle();
    test_cfg_err();
    test_single();
    test_start_ignored();
    test_reset_midrun();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
